csd_conv_param: RTL and testbench
=================================

CSD_CONV_PARAM -- requirements
Module: csd_conv_param

Interface
REQ-001 Parameter WIDTH, 8, input operand width in bits; legal range 2..32.
REQ-002 Parameter CNT_W, $clog2(WIDTH+2), width of count and length outputs.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a conversion; accepted only when ready=1.
REQ-006 din  input  WIDTH  operand, sampled on the accepted start cycle.
REQ-007 signed_mode  input  1  1 = din is two's complement; 0 = din is unsigned; sampled with din.
REQ-008 ready  output  1  block can accept start this cycle.
REQ-009 busy  output  1  conversion in progress.
REQ-010 done  output  1  one-cycle pulse; results are valid.
REQ-011 dout_pos  output  WIDTH+1  bit i = 1 means CSD digit i is +1.
REQ-012 dout_neg  output  WIDTH+1  bit i = 1 means CSD digit i is -1.
REQ-013 nz_count  output  CNT_W  number of nonzero CSD digits.
REQ-014 len  output  CNT_W  index of the highest nonzero digit plus 1; 0 for a zero operand.

Function
REQ-015 The state machine SHALL have three states: IDLE, SCAN and DONE.
REQ-016 ready SHALL be 1 in IDLE and DONE and 0 in SCAN; busy SHALL be 1 only in SCAN; done SHALL be 1 only in DONE.
REQ-017 An accepted start SHALL cause the following loads:
  - working register r (WIDTH+2 bits, signed) loads din, sign-extended when signed_mode=1 and zero-extended otherwise;
  - digit index clears to 0;
  - dout_pos, dout_neg, nz_count and len clear to 0;
  - state goes to SCAN.
REQ-018 In SCAN with r==0, the state SHALL go to DONE with no digit emitted (early exit).
REQ-019 In SCAN with r!=0, one digit SHALL be emitted per cycle at the current index, as follows:
  - r[1:0]==00 or 10: digit 0; r <= r>>>1;
  - r[1:0]==01: digit +1; r <= (r-1)>>>1;
  - r[1:0]==11: digit -1; r <= (r+1)>>>1.
REQ-020 For each nonzero digit emitted, the block SHALL set the corresponding dout_pos or dout_neg bit, increment nz_count, and set len to index+1.
REQ-021 The digit index SHALL increment on every SCAN cycle in which r!=0, and SHALL never exceed WIDTH.
REQ-022 Latency: with start accepted at cycle t0 and a result of length L, done SHALL assert at t0+2+L.
REQ-023 DONE SHALL last exactly one cycle and return to IDLE unless start is accepted in that cycle, in which case it SHALL go to SCAN (back-to-back operation).
REQ-024 Outputs SHALL hold their values from DONE until the next accepted start.
REQ-025 start SHALL be ignored while busy=1; din and signed_mode changes during SCAN SHALL have no effect.
REQ-026 Results SHALL satisfy all of the following:
  - dout_pos & dout_neg == 0;
  - no two adjacent nonzero digits;
  - sum of (dout_pos[i] - dout_neg[i]) * 2^i equals the interpreted value of din.
REQ-027 Arithmetic on r SHALL never overflow: width WIDTH+2 covers unsigned 2^WIDTH-1 +1 and signed -2^(WIDTH-1) -1.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set the following, regardless of state, including mid-SCAN:
  - state = IDLE;
  - r, index, dout_pos, dout_neg, nz_count and len = 0;
  - done = 0, busy = 0, ready = 1.
REQ-029 reset SHALL take priority over start in the same cycle.

Verification (WIDTH=8, start accepted at t0)
REQ-030 Unsigned din=8'h07 -> at t0+6: done=1, dout_pos=9'h008, dout_neg=9'h001, nz_count=2, len=4.
REQ-031 Unsigned din=8'hFF -> at t0+11: done=1, dout_pos=9'h100, dout_neg=9'h001, nz_count=2, len=9.
REQ-032 Signed din=8'hFF (-1) -> at t0+3: done=1, dout_pos=0, dout_neg=9'h001, nz_count=1, len=1; signed din=8'h80 (-128) -> at t0+10: dout_neg=9'h080, dout_pos=0, len=8.
REQ-033 din=0 in either mode -> at t0+2: done=1, all results 0; unsigned din=8'h55 -> at t0+9: dout_pos=9'h055, dout_neg=0, nz_count=4, len=7.
REQ-034 A start pulse with different din during SCAN -> ignored; results match the first operand. A start held high in the DONE cycle -> a new conversion begins with no IDLE cycle.
REQ-035 reset asserted at t0+3 of an 8'hFF conversion -> next cycle: IDLE, ready=1, all outputs 0, no done pulse. Random sweep of all 512 din/mode combinations -> REQ-026 holds for every result.

Source files
------------

// File: rtl/csd_conv_param.sv
// rtl/csd_conv_param.sv - sequential canonical-signed-digit converter, one digit per cycle
// Scans a WIDTH-bit operand LSB first and emits CSD digits as +1/-1 bit masks.
module csd_conv_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             signed_mode,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   dout_pos,
  output logic [WIDTH:0]   dout_neg,
  output logic [CNT_W-1:0] nz_count,
  output logic [CNT_W-1:0] len
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state, state_nx;
  logic signed [WIDTH+1:0] r;
  logic signed [WIDTH+1:0] r_ext;
  logic signed [WIDTH+1:0] r_dec;
  logic signed [WIDTH+1:0] r_inc;
  logic [CNT_W-1:0]        idx;
  logic [WIDTH:0]          digit_mask;
  logic                    accept;

  // Two guard bits keep r-1 / r+1 free of overflow for both operand types.
  assign r_ext      = signed_mode ? {{2{din[WIDTH-1]}}, din} : {2'b00, din};
  assign r_dec      = r - {{(WIDTH+1){1'b0}}, 1'b1};
  assign r_inc      = r + {{(WIDTH+1){1'b0}}, 1'b1};
  assign digit_mask = {{WIDTH{1'b0}}, 1'b1} << idx;
  assign accept     = start && (state != SCAN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (r == '0) state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        done     = 1'b1;
        state_nx = start ? SCAN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r        <= '0;
      idx      <= '0;
      dout_pos <= '0;
      dout_neg <= '0;
      nz_count <= '0;
      len      <= '0;
    end else if (accept) begin
      r        <= r_ext;
      idx      <= '0;
      dout_pos <= '0;
      dout_neg <= '0;
      nz_count <= '0;
      len      <= '0;
    end else if (state == SCAN && r != '0) begin
      case (r[1:0])
        2'b01: begin
          r        <= r_dec >>> 1;
          dout_pos <= dout_pos | digit_mask;
          nz_count <= nz_count + CNT_W'(1);
          len      <= idx + CNT_W'(1);
        end
        2'b11: begin
          r        <= r_inc >>> 1;
          dout_neg <= dout_neg | digit_mask;
          nz_count <= nz_count + CNT_W'(1);
          len      <= idx + CNT_W'(1);
        end
        default: r <= r >>> 1;
      endcase
      // The top digit sits at index WIDTH; the index parks there.
      idx <= (idx == CNT_W'(WIDTH)) ? idx : idx + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_csd_conv_param.sv
// tb/tb_csd_conv_param.sv - randomized self-checking bench for csd_conv_param
// Reference CSD comes from the carry-based formula x+(x>>1), not a digit scan.
module tb_csd_conv_param;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  din;
  logic          signed_mode;
  logic          ready, busy, done;
  logic [W:0]    dout_pos, dout_neg;
  logic [CW-1:0] nz_count, len;

  int checks = 0;
  int errors = 0;

  csd_conv_param #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .din(din), .signed_mode(signed_mode),
    .ready(ready), .busy(busy), .done(done), .dout_pos(dout_pos), .dout_neg(dout_neg),
    .nz_count(nz_count), .len(len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint value_of(input logic [W-1:0] d, input bit m);
    return m ? longint'($signed(d)) : longint'(d);
  endfunction

  function automatic void model(input logic [W-1:0] d, input bit m,
                                output logic [W:0] p, output logic [W:0] n,
                                output int nz, output int ln);
    longint v, a, xh, x3, c, pp, nn, t;
    logic [W:0] any;
    v  = value_of(d, m);
    a  = (v < 0) ? -v : v;
    xh = a >> 1;
    x3 = a + xh;
    c  = xh ^ x3;
    pp = x3 & c;
    nn = xh & c;
    if (v < 0) begin
      t = pp; pp = nn; nn = t;
    end
    p   = pp[W:0];
    n   = nn[W:0];
    any = p | n;
    nz  = $countones(any);
    ln  = 0;
    for (int i = 0; i <= W; i++) if (any[i]) ln = i + 1;
  endfunction

  // Called right after an edge; the start is accepted at the next edge.
  task automatic launch(input logic [W-1:0] d, input bit m);
    din = d; signed_mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din = W'($urandom);
    signed_mode = 1'($urandom);
  endtask

  task automatic finish_conv(input logic [W-1:0] d, input bit m, input bit glitch);
    logic [W:0] ep, en;
    int enz, eln, k;
    longint sum;
    model(d, m, ep, en, enz, eln);
    k = 1;
    chk("busy_in_scan", busy, 1);
    chk("ready_in_scan", ready, 0);
    if (glitch) begin
      start = 1'b1;
      din = ~d;
    end
    while (done !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    chk("latency", k, 2 + eln);
    chk("dout_pos", dout_pos, ep);
    chk("dout_neg", dout_neg, en);
    chk("nz_count", nz_count, enz);
    chk("len", len, eln);
    sum = 0;
    for (int i = 0; i <= W; i++)
      sum += (longint'(dout_pos[i]) - longint'(dout_neg[i])) <<< i;
    chk("csd_value", sum, value_of(d, m));
    chk("disjoint", dout_pos & dout_neg, 0);
    chk("nonadjacent", (dout_pos | dout_neg) & ((dout_pos | dout_neg) >> 1), 0);
  endtask

  initial begin
    logic [W:0] hp, hn;
    logic [CW-1:0] hz, hl;
    int order[512];
    int tmp, j, pulses;

    reset = 1'b1; start = 1'b0; din = '0; signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pos", dout_pos, 0);
    chk("rst_neg", dout_neg, 0);
    chk("rst_nz", nz_count, 0);
    chk("rst_len", len, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed operands from the specification's examples.
    launch(8'h07, 1'b0); finish_conv(8'h07, 1'b0, 1'b0);
    chk("u07_pos_const", dout_pos, 9'h008);
    chk("u07_neg_const", dout_neg, 9'h001);
    launch(8'hFF, 1'b0); finish_conv(8'hFF, 1'b0, 1'b0);
    launch(8'hFF, 1'b1); finish_conv(8'hFF, 1'b1, 1'b0);
    launch(8'h80, 1'b1); finish_conv(8'h80, 1'b1, 1'b0);
    launch(8'h00, 1'b0); finish_conv(8'h00, 1'b0, 1'b0);
    launch(8'h00, 1'b1); finish_conv(8'h00, 1'b1, 1'b0);
    launch(8'h55, 1'b0); finish_conv(8'h55, 1'b0, 1'b0);

    // Results hold after the done pulse.
    hp = dout_pos; hn = dout_neg; hz = nz_count; hl = len;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_done_low", done, 0);
      chk("hold_ready", ready, 1);
    end
    chk("hold_pos", dout_pos, hp);
    chk("hold_neg", dout_neg, hn);
    chk("hold_nz", nz_count, hz);
    chk("hold_len", len, hl);

    // A start during SCAN with another operand is ignored.
    launch(8'h07, 1'b0); finish_conv(8'h07, 1'b0, 1'b1);

    // Back-to-back: next start issued in the DONE cycle.
    chk("b2b_ready_in_done", ready, 1);
    launch(8'hFF, 1'b0);
    finish_conv(8'hFF, 1'b0, 1'b0);
    launch(8'h80, 1'b1);
    finish_conv(8'h80, 1'b1, 1'b0);

    // Reset during SCAN of 8'hFF.
    launch(8'hFF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_ready", ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pos", dout_pos, 0);
    chk("midrst_neg", dout_neg, 0);
    chk("midrst_nz", nz_count, 0);
    chk("midrst_len", len, 0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("midrst_no_activity", pulses, 0);

    // Reset wins over start.
    din = 8'hFF; signed_mode = 1'b0; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_ready", ready, 1);
    @(posedge clk); #1;
    chk("rst_prio_busy2", busy, 0);

    // All 512 operand/mode combinations in shuffled order.
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 512; i++) begin
      launch(order[i][7:0], order[i][8]);
      finish_conv(order[i][7:0], order[i][8], 1'($urandom));
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
